// File: rtl/req_burst_pkg.sv
// req_burst_pkg: shared definitions for the request burst shaper.
//   - one-hot channel state encoding and its width
//   - default values for LEN_W, GAP_CYC and TMO_CYC
//   - cnt_width(): counter width able to hold a given maximum value
package req_burst_pkg;

    localparam int ST_W        = 4;
    localparam int LEN_W_DEF   = 4;
    localparam int GAP_CYC_DEF = 1;
    localparam int TMO_CYC_DEF = 16;

    typedef enum logic [ST_W-1:0] {
        CH_IDLE = 4'b0001,
        CH_REQ  = 4'b0010,
        CH_XFER = 4'b0100,
        CH_GAP  = 4'b1000
    } ch_state_e;

    // Bits needed to represent max_val (never less than one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/req_burst_if.sv
// req_burst_if: job-descriptor, arbiter-grant and status signals of both
// channels of req_burst_ctrl.
//   master : job source / arbiter side (drives jobs and grants)
//   slave  : req_burst_ctrl (drives ready, requests and status pulses)
interface req_burst_if
    import req_burst_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF
);
    logic             job_valid_0;
    logic [LEN_W-1:0] job_len_0;
    logic             job_ready_0;
    logic             job_valid_1;
    logic [LEN_W-1:0] job_len_1;
    logic             job_ready_1;
    logic             gen_0;
    logic             gen_1;
    logic             req_0;
    logic             req_1;
    logic             beat_0;
    logic             beat_1;
    logic             done_0;
    logic             done_1;
    logic             tmo_0;
    logic             tmo_1;

    modport master (
        output job_valid_0, job_len_0, job_valid_1, job_len_1, gen_0, gen_1,
        input  job_ready_0, job_ready_1, req_0, req_1,
        input  beat_0, beat_1, done_0, done_1, tmo_0, tmo_1
    );

    modport slave (
        input  job_valid_0, job_len_0, job_valid_1, job_len_1, gen_0, gen_1,
        output job_ready_0, job_ready_1, req_0, req_1,
        output beat_0, beat_1, done_0, done_1, tmo_0, tmo_1
    );
endinterface

// File: rtl/req_burst_chan.sv
// req_chan: one request-shaping channel.
//   Accepts a job (beat count, 0 = 2**LEN_W), holds req until that many
//   beats are granted, then keeps req low for GAP_CYC cycles.
//   Optional macro REQ_TIMEOUT_EN: abandons a request that waits TMO_CYC
//   cycles for its first grant (tmo pulse); otherwise tmo is tied 0.
// Ports: clk, reset (async, active low), job_valid/job_len/job_ready,
//        gen (grant in), req (request out), beat/done/tmo (pulses).
module req_chan
    import req_burst_pkg::*;
#(
    parameter int LEN_W   = LEN_W_DEF,
    parameter int GAP_CYC = GAP_CYC_DEF,
    parameter int TMO_CYC = TMO_CYC_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             job_valid,
    input  logic [LEN_W-1:0] job_len,
    output logic             job_ready,
    input  logic             gen,
    output logic             req,
    output logic             beat,
    output logic             done,
    output logic             tmo
);
    localparam int               GAP_W    = cnt_width(GAP_CYC);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1'b1);
    localparam logic [LEN_W-1:0] REM_ONE  = LEN_W'(1'b1);

    ch_state_e        state_r, state_nxt_s;
    logic [LEN_W-1:0] rem_r, rem_nxt_s;
    logic [GAP_W-1:0] gap_r, gap_nxt_s;
    logic             req_s, beat_s, last_s, tmo_s;

    // Outputs decode straight from the registered state, so req is glitch-free.
    assign req_s     = (state_r == CH_REQ) || (state_r == CH_XFER);
    assign beat_s    = req_s & gen;
    assign last_s    = beat_s && (rem_r == REM_ONE);
    assign job_ready = (state_r == CH_IDLE);
    assign req       = req_s;
    assign beat      = beat_s;
    assign done      = last_s;
    assign tmo       = tmo_s;

`ifdef REQ_TIMEOUT_EN
    localparam int                WAIT_W    = cnt_width(TMO_CYC);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TMO_CYC - 1);
    logic [WAIT_W-1:0] wait_r, wait_nxt_s;

    // The wait counter only runs while waiting for the first grant.
    assign tmo_s = (state_r == CH_REQ) && !beat_s && (wait_r == WAIT_LAST);

    // Wait counter next value: count idle CH_REQ cycles, clear otherwise.
    always_comb begin
        wait_nxt_s = '0;
        if ((state_r == CH_REQ) && !beat_s && !tmo_s) begin
            wait_nxt_s = wait_r + WAIT_W'(1'b1);
        end else begin
            wait_nxt_s = '0;
        end
    end

    // Wait counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_r <= '0;
        end else begin
            wait_r <= wait_nxt_s;
        end
    end
`else
    assign tmo_s = 1'b0;
`endif

    // Next-state and counter logic.
    always_comb begin
        state_nxt_s = state_r;
        rem_nxt_s   = rem_r;
        gap_nxt_s   = gap_r;
        case (state_r)
            CH_IDLE: begin
                if (job_valid) begin
                    rem_nxt_s   = job_len;
                    state_nxt_s = CH_REQ;
                end else begin
                    state_nxt_s = CH_IDLE;
                end
            end
            CH_REQ, CH_XFER: begin
                if (beat_s) begin
                    // Length 0 wraps through 2**LEN_W-1 down to 1.
                    rem_nxt_s = rem_r - REM_ONE;
                    if (last_s) begin
                        state_nxt_s = CH_GAP;
                        gap_nxt_s   = GAP_LOAD;
                    end else begin
                        state_nxt_s = CH_XFER;
                    end
                end else if (tmo_s) begin
                    state_nxt_s = CH_GAP;
                    gap_nxt_s   = GAP_LOAD;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            CH_GAP: begin
                gap_nxt_s = gap_r - GAP_ONE;
                if (gap_r == GAP_ONE) begin
                    state_nxt_s = CH_IDLE;
                end else begin
                    state_nxt_s = CH_GAP;
                end
            end
            default: begin
                state_nxt_s = CH_IDLE;
                rem_nxt_s   = '0;
                gap_nxt_s   = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= CH_IDLE;
            rem_r   <= '0;
            gap_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            rem_r   <= rem_nxt_s;
            gap_r   <= gap_nxt_s;
        end
    end

endmodule

// File: rtl/req_burst_ctrl.sv
// req_burst_ctrl: two independent request shapers feeding the two-requester
// grant arbiter. No cross-channel logic; the arbiter owns mutual exclusion.
// Optional macro REQ_TIMEOUT_EN enables the per-channel request timeout.
// Ports: clk, reset (async, active low), bus (req_burst_if.slave: job
//        handshakes, grants, requests and beat/done/tmo pulses per channel).
module req_burst_ctrl
    import req_burst_pkg::*;
#(
    parameter int LEN_W   = LEN_W_DEF,
    parameter int GAP_CYC = GAP_CYC_DEF,
    parameter int TMO_CYC = TMO_CYC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    req_burst_if.slave  bus
);

    req_chan #(.LEN_W(LEN_W), .GAP_CYC(GAP_CYC), .TMO_CYC(TMO_CYC)) u_chan_0 (
        .clk       (clk),
        .reset     (reset),
        .job_valid (bus.job_valid_0),
        .job_len   (bus.job_len_0),
        .job_ready (bus.job_ready_0),
        .gen       (bus.gen_0),
        .req       (bus.req_0),
        .beat      (bus.beat_0),
        .done      (bus.done_0),
        .tmo       (bus.tmo_0)
    );

    req_chan #(.LEN_W(LEN_W), .GAP_CYC(GAP_CYC), .TMO_CYC(TMO_CYC)) u_chan_1 (
        .clk       (clk),
        .reset     (reset),
        .job_valid (bus.job_valid_1),
        .job_len   (bus.job_len_1),
        .job_ready (bus.job_ready_1),
        .gen       (bus.gen_1),
        .req       (bus.req_1),
        .beat      (bus.beat_1),
        .done      (bus.done_1),
        .tmo       (bus.tmo_1)
    );

endmodule

// File: tb/tb_req_burst_ctrl.sv
// tb_req_burst_ctrl: directed and randomized checks of req_burst_ctrl
// against a beat-counting model of each channel.
module tb_req_burst_ctrl;
    localparam int LEN_W   = 4;
    localparam int GAP_CYC = 1;
    localparam int TMO_CYC = 16;
    localparam int FULL    = 1 << LEN_W;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    req_burst_if #(.LEN_W(LEN_W)) bus ();

    req_burst_ctrl #(.LEN_W(LEN_W), .GAP_CYC(GAP_CYC), .TMO_CYC(TMO_CYC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic             vld [2];
    logic [LEN_W-1:0] len [2];
    logic             gen [2];
    logic a_req [2], a_ready [2], a_beat [2], a_done [2], a_tmo [2];

    assign bus.job_valid_0 = vld[0];
    assign bus.job_len_0   = len[0];
    assign bus.gen_0       = gen[0];
    assign bus.job_valid_1 = vld[1];
    assign bus.job_len_1   = len[1];
    assign bus.gen_1       = gen[1];
    assign a_req[0]   = bus.req_0;
    assign a_req[1]   = bus.req_1;
    assign a_ready[0] = bus.job_ready_0;
    assign a_ready[1] = bus.job_ready_1;
    assign a_beat[0]  = bus.beat_0;
    assign a_beat[1]  = bus.beat_1;
    assign a_done[0]  = bus.done_0;
    assign a_done[1]  = bus.done_1;
    assign a_tmo[0]   = bus.tmo_0;
    assign a_tmo[1]   = bus.tmo_1;

    int n_cmp = 0;
    int n_err = 0;

    // Model: beats still owed, gap cycles left, beats delivered, wait cycles.
    int m_left [2];
    int m_gap  [2];
    int m_got  [2];
    int m_wait [2];
    // Outputs seen at the latest sampling point.
    logic s_req [2], s_ready [2], s_beat [2], s_done [2], s_tmo [2];

    task automatic cmp_bit(input string nm, input int c, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s ch%0d: got %0b, expected %0b (t=%0t)", nm, c, act, exp, $time);
        end
    endtask

    task automatic cmp_int(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < 2; c++) begin
            m_left[c] = 0;
            m_gap[c]  = 0;
            m_got[c]  = 0;
            m_wait[c] = 0;
        end
    endtask

    // Compare every output against the model, then advance the model.
    task automatic check_and_step();
        for (int c = 0; c < 2; c++) begin
            logic e_req, e_ready, e_beat, e_done, e_tmo;
            e_req   = (m_left[c] > 0);
            e_ready = (m_left[c] == 0) && (m_gap[c] == 0);
            e_beat  = e_req && gen[c];
            e_done  = e_beat && (m_left[c] == 1);
            e_tmo   = 1'b0;
`ifdef REQ_TIMEOUT_EN
            e_tmo   = e_req && !e_beat && (m_got[c] == 0) && (m_wait[c] == TMO_CYC - 1);
`endif
            cmp_bit("req", c, a_req[c], e_req);
            cmp_bit("job_ready", c, a_ready[c], e_ready);
            cmp_bit("beat", c, a_beat[c], e_beat);
            cmp_bit("done", c, a_done[c], e_done);
            cmp_bit("tmo", c, a_tmo[c], e_tmo);
            s_req[c]   = a_req[c];
            s_ready[c] = a_ready[c];
            s_beat[c]  = a_beat[c];
            s_done[c]  = a_done[c];
            s_tmo[c]   = a_tmo[c];
            if (e_ready && vld[c]) begin
                m_left[c] = (len[c] == '0) ? FULL : int'(len[c]);
                m_got[c]  = 0;
                m_wait[c] = 0;
            end else if (e_beat) begin
                m_left[c]--;
                m_got[c]++;
                m_wait[c] = 0;
                if (m_left[c] == 0) m_gap[c] = GAP_CYC;
            end else if (e_tmo) begin
                m_left[c] = 0;
                m_wait[c] = 0;
                m_gap[c]  = GAP_CYC;
            end else if (e_req && m_got[c] == 0) begin
                m_wait[c]++;
            end else if (m_gap[c] > 0) begin
                m_gap[c]--;
            end
        end
    endtask

    // One clock: check on the falling edge, return 1 time unit after rising edge.
    task automatic tick();
        @(negedge clk);
        if (reset) check_and_step();
        else       model_clear();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rq, bt, dn, dn_at, rdy_at, tm_at;
        logic [8:0] pat;
        for (int c = 0; c < 2; c++) begin
            vld[c] = 1'b0;
            len[c] = '0;
            gen[c] = 1'b0;
        end
        model_clear();
        repeat (3) tick();
        reset = 1'b1;
        cmp_bit("rst_ready", 0, a_ready[0], 1'b1);
        cmp_bit("rst_req", 1, a_req[1], 1'b0);

        // Length 3, grant tied to request.
        vld[0] = 1'b1; len[0] = 4'd3; tick(); vld[0] = 1'b0;
        rq = 0; bt = 0; dn = 0; dn_at = 0; rdy_at = -1;
        for (int i = 1; i <= 12; i++) begin
            gen[0] = a_req[0];
            tick();
            if (s_req[0]) rq++;
            if (s_beat[0]) bt++;
            if (s_done[0]) begin dn++; dn_at = bt; end
            if (s_ready[0] && rdy_at < 0) rdy_at = i;
        end
        gen[0] = 1'b0;
        cmp_int("len3_req_cycles", rq, 3);
        cmp_int("len3_beats", bt, 3);
        cmp_int("len3_done_count", dn, 1);
        cmp_int("len3_done_on_beat", dn_at, 3);
        cmp_int("len3_ready_latency", rdy_at, 3 + GAP_CYC + 1);

        // Length 0 on channel 1, continuous grant (also while idle/gap).
        gen[1] = 1'b1; vld[1] = 1'b1; len[1] = 4'd0; tick(); vld[1] = 1'b0;
        bt = 0; dn = 0; dn_at = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (s_beat[1]) bt++;
            if (s_done[1]) begin dn++; dn_at = bt; end
        end
        gen[1] = 1'b0;
        cmp_int("len0_beats", bt, 16);
        cmp_int("len0_done_count", dn, 1);
        cmp_int("len0_done_on_beat", dn_at, 16);

        // Length 2 with grant withheld for 5 cycles.
        vld[0] = 1'b1; len[0] = 4'd2; tick(); vld[0] = 1'b0;
        rq = 0; bt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (s_req[0]) rq++;
            if (s_beat[0]) bt++;
        end
        cmp_int("nogrant_req_cycles", rq, 5);
        cmp_int("nogrant_beats", bt, 0);
        gen[0] = 1'b1; bt = 0; dn = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (s_beat[0]) bt++;
            if (s_done[0]) dn++;
        end
        gen[0] = 1'b0;
        cmp_int("late_grant_beats", bt, 2);
        cmp_int("late_grant_done", dn, 1);

        // Length 4 with grant dropped for 2 cycles mid-burst.
        vld[0] = 1'b1; len[0] = 4'd4; tick(); vld[0] = 1'b0;
        pat = 9'b111110011;
        rq = 0; bt = 0; dn = 0;
        for (int i = 0; i < 9; i++) begin
            gen[0] = pat[i];
            tick();
            if (s_req[0]) rq++;
            if (s_beat[0]) bt++;
            if (s_done[0]) dn++;
        end
        gen[0] = 1'b0;
        cmp_int("drop_req_cycles", rq, 6);
        cmp_int("drop_beats", bt, 4);
        cmp_int("drop_done", dn, 1);

        // Reset mid-burst of a length-8 job.
        vld[0] = 1'b1; len[0] = 4'd8; tick(); vld[0] = 1'b0;
        gen[0] = 1'b1;
        repeat (3) tick();
        cmp_bit("pre_reset_req", 0, a_req[0], 1'b1);
        reset = 1'b0;
        #1;
        cmp_bit("async_req_drop", 0, a_req[0], 1'b0);
        cmp_bit("reset_no_done", 0, a_done[0], 1'b0);
        model_clear();
        repeat (2) tick();
        reset = 1'b1;
        cmp_bit("post_reset_ready", 0, a_ready[0], 1'b1);
        gen[0] = 1'b0;
        repeat (2) tick();

`ifdef REQ_TIMEOUT_EN
        // Request never granted: abandoned on the TMO_CYC-th wait cycle.
        vld[1] = 1'b1; len[1] = 4'd5; tick(); vld[1] = 1'b0;
        rq = 0; tm_at = -1; rdy_at = -1;
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (s_req[1]) rq++;
            if (s_tmo[1] && tm_at < 0) tm_at = i;
            if (s_ready[1] && rdy_at < 0) rdy_at = i;
        end
        cmp_int("tmo_cycle", tm_at, TMO_CYC);
        cmp_int("tmo_req_cycles", rq, TMO_CYC);
        cmp_int("tmo_ready_at", rdy_at, TMO_CYC + GAP_CYC + 1);
`else
        tm_at = 0;
`endif

        // Randomized traffic, with occasional long grant droughts.
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < 2; c++) begin
                vld[c] = ($urandom_range(0, 2) == 0);
                len[c] = LEN_W'($urandom);
                if ((i / 40) % 4 == 3) gen[c] = ($urandom_range(0, 15) == 0);
                else                   gen[c] = ($urandom_range(0, 3) != 0);
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/req_burst_ctrl.md
Name: req_burst_ctrl

Overview:
- Upstream request shaper for the two-requester grant arbiter: converts per-channel job descriptors (beat count) into the req_0/req_1 levels the arbiter consumes.
- Holds each request until the arbiter has granted the full number of beats, then drops the request for a programmable gap so the arbiter returns to its idle state and can serve the other side.
- Reports each granted beat and end-of-burst back to the job source.

Parameters:
- LEN_W, 4, width of the job length field; a length of 0 encodes 2**LEN_W beats.
- GAP_CYC, 1, cycles req_c stays low after a burst before the channel accepts a new job; minimum 1.
- TMO_CYC, 16, request wait limit in cycles; used only with REQ_TIMEOUT_EN.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- job_valid_0  in  1  channel 0 job offered
- job_len_0  in  LEN_W  channel 0 burst length
- job_ready_0  out  1  channel 0 can accept a job
- job_valid_1, job_len_1, job_ready_1: same as channel 0, for channel 1
- gen_0  in  1  grant from arbiter, channel 0
- gen_1  in  1  grant from arbiter, channel 1
- req_0  out  1  request to arbiter, channel 0 (registered)
- req_1  out  1  request to arbiter, channel 1 (registered)
- beat_0 / beat_1  out  1  pulse: one granted beat consumed
- done_0 / done_1  out  1  pulse: last beat of the burst consumed
- tmo_0 / tmo_1  out  1  pulse: request abandoned (REQ_TIMEOUT_EN only; otherwise tied 0)

Behaviour:
- Channels are fully independent and identical. There is no cross-channel logic; mutual exclusion belongs to the arbiter.
- Per-channel one-hot FSM with 4 states:
  - CH_IDLE = 4'b0001
  - CH_REQ = 4'b0010
  - CH_XFER = 4'b0100
  - CH_GAP = 4'b1000
- Reset (reset low, asynchronous):
  - state goes to CH_IDLE; remaining and gap counters clear.
  - req_c = 0 immediately; beat_c, done_c and tmo_c = 0.
  - job_ready_c = 1 once reset is released.
  - Reset asserted mid-burst aborts the burst silently: no done_c pulse.
- Decoded outputs:
  - job_ready_c = (state == CH_IDLE).
  - req_c = state is CH_REQ or CH_XFER; decoded from the registered state, so it is glitch-free.
- CH_IDLE:
  - On job_valid_c && job_ready_c, latch job_len_c into the remaining counter and go to CH_REQ.
  - req_c rises in the cycle after acceptance.
- Beat definition: in CH_REQ or CH_XFER, any cycle with gen_c = 1 is a beat.
  - beat_c = req_c & gen_c, combinational, same cycle as the beat.
  - remaining decrements by 1 at the clock edge ending the beat, with modulo-2**LEN_W wrap.
- Last beat: a beat while remaining == 1.
  - done_c = 1 in that same cycle; next state is CH_GAP with the gap counter loaded to GAP_CYC.
  - A single-beat job goes CH_REQ to CH_GAP directly.
- CH_REQ with a non-last beat: go to CH_XFER.
- CH_REQ with no grant: stay in CH_REQ, req_c held high.
- CH_XFER with gen_c = 0 (grant lost mid-burst): stay in CH_XFER, req_c held, count frozen.
- CH_GAP:
  - req_c = 0; the gap counter decrements each cycle.
  - Go to CH_IDLE in the cycle after it reaches 1.
  - req_c is low for exactly GAP_CYC cycles.
- Length 0: 2**LEN_W beats (16 at default). The counter wraps 0 → 15 → … → 1.
- A grant while in CH_IDLE or CH_GAP is ignored: no beat, no count.
- Latency:
  - job accept to req_c high: 1 cycle.
  - With an immediately granting arbiter, a job of L beats occupies L + GAP_CYC + 1 cycles from accept to job_ready_c high again.

Optional Feature:
- Macro: REQ_TIMEOUT_EN.
- Defined:
  - A per-channel wait counter runs while in CH_REQ and clears on any beat.
  - On reaching TMO_CYC cycles with no grant, pulse tmo_c for 1 cycle, discard the job and go to CH_GAP.
  - CH_XFER is not timed.
- Undefined: no wait counter is built; tmo_c is constant 0 and CH_REQ waits indefinitely.

Decomposition:
- Package req_burst_pkg holds:
  - the state constants CH_IDLE, CH_REQ, CH_XFER, CH_GAP;
  - the state-width constant (4);
  - default values for LEN_W, GAP_CYC and TMO_CYC.
- Sub-module req_chan implements one channel: FSM, remaining counter, gap counter and optional timeout.
- req_burst_ctrl instantiates req_chan twice and only wires ports.

Test Plan:
- Reset released, then job_valid_0 with len 3 and gen_0 tied to req_0:
  - req_0 high for 3 cycles; beat_0 on each;
  - done_0 on the 3rd; req_0 low 1 cycle; job_ready_0 high after.
- len 0 on channel 1 with continuous grant:
  - exactly 16 beat_1 pulses; a single done_1 on the 16th.
- gen_0 held low for 5 cycles after a len-2 job:
  - req_0 stays high; no beat_0;
  - grant then given → 2 beats, done_0.
- gen_0 dropped for 2 cycles mid-burst (len 4):
  - count frozen; req_0 stays high; 4 beats total still delivered.
- reset driven low during CH_XFER of a len-8 job:
  - req_0 falls without waiting for a clock edge; no done_0;
  - job_ready_0 = 1 after reset release.
- REQ_TIMEOUT_EN defined, TMO_CYC = 16, gen_1 never asserted:
  - tmo_1 pulses in cycle 16 of the wait; req_1 drops;
  - channel returns to CH_IDLE after GAP_CYC cycles.
